// File: rtl/band_feature_serializer_pkg.sv
// ----------------------------------------------------------------------------
// band_feature_serializer_pkg
// Shared definitions for the band feature serializer.
//   NUM_FEATURES  : number of words per epoch (five bands plus their total)
//   IDX_WIDTH     : width of the feature index
//   feature_idx_e : word order on the output stream
//   state_e       : serializer FSM states
// ----------------------------------------------------------------------------
package band_feature_serializer_pkg;

    localparam int NUM_FEATURES = 6;
    localparam int IDX_WIDTH    = 3;

    typedef enum logic [IDX_WIDTH-1:0] {
        DELTA = 3'd0,
        THETA = 3'd1,
        ALPHA = 3'd2,
        BETA  = 3'd3,
        GAMMA = 3'd4,
        TOTAL = 3'd5
    } feature_idx_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage

// File: rtl/band_feature_serializer_band_sum_sat.sv
// ----------------------------------------------------------------------------
// band_sum_sat
// Combinational sum of five signed band powers, saturated to the signed
// DATA_WIDTH range.
//   band0_i..band4_i : signed band powers
//   sum_o            : saturated signed sum
// ----------------------------------------------------------------------------
module band_sum_sat #(
    parameter int DATA_WIDTH = 32
) (
    input  logic signed [DATA_WIDTH-1:0] band0_i,
    input  logic signed [DATA_WIDTH-1:0] band1_i,
    input  logic signed [DATA_WIDTH-1:0] band2_i,
    input  logic signed [DATA_WIDTH-1:0] band3_i,
    input  logic signed [DATA_WIDTH-1:0] band4_i,
    output logic signed [DATA_WIDTH-1:0] sum_o
);

    // Three guard bits hold the sum of five operands without wrapping.
    localparam int SW = DATA_WIDTH + 3;

    localparam logic signed [SW-1:0] MAX_S = {{4{1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_S = {{4{1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [SW-1:0] wide_sum;

    always_comb begin
        wide_sum = {{3{band0_i[DATA_WIDTH-1]}}, band0_i}
                 + {{3{band1_i[DATA_WIDTH-1]}}, band1_i}
                 + {{3{band2_i[DATA_WIDTH-1]}}, band2_i}
                 + {{3{band3_i[DATA_WIDTH-1]}}, band3_i}
                 + {{3{band4_i[DATA_WIDTH-1]}}, band4_i};

        if (wide_sum > MAX_S) begin
            sum_o = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (wide_sum < MIN_S) begin
            sum_o = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            sum_o = wide_sum[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/band_feature_serializer.sv
// ----------------------------------------------------------------------------
// band_feature_serializer
// Captures one epoch of five band powers plus their saturated total and
// streams them as six words over a valid/ready interface.
//   clk, rst            : clock, asynchronous active-high reset
//   en                  : global enable; when low everything freezes
//   *_band_power        : band powers from the PSD stage
//   i_power_valid       : one-cycle pulse marking the band powers valid
//   o_feature_data/idx  : current word and its index (0..5)
//   o_feature_valid     : word valid; i_feature_ready completes a handshake
//   o_feature_last      : marks the total word (idx 5)
//   o_busy              : an epoch is held or being sent
//   o_overrun           : sticky, an epoch arrived while busy and was dropped
//   o_epoch_count       : wrapping count of fully transmitted epochs
// ----------------------------------------------------------------------------
module band_feature_serializer
    import band_feature_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] delta_band_power,
    input  logic signed [DATA_WIDTH-1:0] theta_band_power,
    input  logic signed [DATA_WIDTH-1:0] alpha_band_power,
    input  logic signed [DATA_WIDTH-1:0] beta_band_power,
    input  logic signed [DATA_WIDTH-1:0] gamma_band_power,
    input  logic                         i_power_valid,
    output logic signed [DATA_WIDTH-1:0] o_feature_data,
    output logic [IDX_WIDTH-1:0]         o_feature_idx,
    output logic                         o_feature_valid,
    input  logic                         i_feature_ready,
    output logic                         o_feature_last,
    output logic                         o_busy,
    output logic                         o_overrun,
    output logic [CNT_WIDTH-1:0]         o_epoch_count
);

    state_e                       state_q, state_d;
    feature_idx_e                 idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0] words_q [NUM_FEATURES];
    logic signed [DATA_WIDTH-1:0] words_d [NUM_FEATURES];
    logic                         overrun_q, overrun_d;
    logic [CNT_WIDTH-1:0]         count_q, count_d;

    logic signed [DATA_WIDTH-1:0] total;
    logic                         handshake;
    logic                         final_hs;
    logic                         capture;

    band_sum_sat #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_band_sum_sat (
        .band0_i (delta_band_power),
        .band1_i (theta_band_power),
        .band2_i (alpha_band_power),
        .band3_i (beta_band_power),
        .band4_i (gamma_band_power),
        .sum_o   (total)
    );

    always_comb begin
        o_feature_valid = (state_q == ST_SEND) && en;
        handshake       = o_feature_valid && i_feature_ready;
        final_hs        = handshake && (idx_q == TOTAL);
        // A new epoch is accepted when idle, or when the slot frees up on
        // the very edge that completes the current epoch.
        capture         = en && i_power_valid && ((state_q == ST_IDLE) || final_hs);
    end

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no
        //       path through the branches below can infer a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        words_d   = words_q;
        overrun_d = overrun_q;
        count_d   = count_q;

        if (handshake) begin
            if (final_hs) begin
                count_d = count_q + CNT_WIDTH'(1);
                state_d = ST_IDLE;
                idx_d   = DELTA;
            end else begin
                idx_d = feature_idx_e'(idx_q + 3'd1);
            end
        end

        if (capture) begin
            words_d = '{delta_band_power, theta_band_power, alpha_band_power,
                        beta_band_power, gamma_band_power, total};
            idx_d   = DELTA;
            state_d = ST_SEND;
        end else if (en && i_power_valid) begin
            overrun_d = 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples
    //       the pre-edge values computed above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= DELTA;
            overrun_q <= 1'b0;
            count_q   <= '0;
            // NOTE: the held words are only six registers and are cleared
            //       so the data output is deterministic straight out of reset.
            for (int i = 0; i < NUM_FEATURES; i++) begin
                words_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
            words_q   <= words_d;
        end
    end

    always_comb begin
        o_feature_idx  = idx_q;
        o_busy         = (state_q == ST_SEND);
        o_feature_last = (state_q == ST_SEND) && (idx_q == TOTAL);
        o_overrun      = overrun_q;
        o_epoch_count  = count_q;
        o_feature_data = '0;
        if ((state_q == ST_SEND) && (int'(idx_q) < NUM_FEATURES)) begin
            o_feature_data = words_q[idx_q];
        end
    end

endmodule
